ahblite_busmatrix_outputstage_rr: RTL and testbench

Parametrised AHB-Lite bus-matrix output stage for one slave port. It merges NUM_PORTS input-stage requesters through an integrated round-robin arbiter with burst locking, and multiplexes the granted address phase onto the slave. The data phase is steered by a registered owner. It replaces the per-slave single-requester output stages and sits between the input stages and each slave in the matrix.

---
 rtl/ahb_pkg.sv | 32 +++
 rtl/ahblite_busmatrix_outputstage_rr_if.sv | 44 ++++
 rtl/ahblite_rr_arbiter.sv | 81 ++++++++
 rtl/ahblite_busmatrix_outputstage_rr.sv | 94 +++++++++
 tb/tb_ahblite_busmatrix_outputstage_rr.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and burst helpers for the bus-matrix blocks.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_e;

  // Beats still to come after the first beat of a fixed-length burst; 0 otherwise.
  function automatic logic [3:0] burst_remaining(hburst_e burst);
    case (burst)
      WRAP4,  INCR4:  return 4'd3;
      WRAP8,  INCR8:  return 4'd7;
      WRAP16, INCR16: return 4'd15;
      default:        return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahblite_busmatrix_outputstage_rr_if.sv
// Bus bundle between the input stages, the output stage and one slave port.
interface ahblite_busmatrix_outputstage_rr_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);

  logic [NUM_PORTS-1:0]        HSEL_SUB;
  logic [NUM_PORTS-1:0]        TRANS_HOLD_SUB;
  logic [NUM_PORTS*ADDR_W-1:0] HADDR_SUB;
  logic [NUM_PORTS*2-1:0]      HTRANS_SUB;
  logic [NUM_PORTS-1:0]        HWRITE_SUB;
  logic [NUM_PORTS*3-1:0]      HSIZE_SUB;
  logic [NUM_PORTS*3-1:0]      HBURST_SUB;
  logic [NUM_PORTS*4-1:0]      HPROT_SUB;
  logic [NUM_PORTS*DATA_W-1:0] HWDATA_SUB;
  logic                        HREADYOUT;

  logic [NUM_PORTS-1:0]        ACTIVE_SUB;
  logic                        HSEL;
  logic [ADDR_W-1:0]           HADDR;
  logic [1:0]                  HTRANS;
  logic                        HWRITE;
  logic [2:0]                  HSIZE;
  logic [2:0]                  HBURST;
  logic [3:0]                  HPROT;
  logic                        HREADY;
  logic [DATA_W-1:0]           HWDATA;

  modport master (
    input  HSEL_SUB, TRANS_HOLD_SUB, HADDR_SUB, HTRANS_SUB, HWRITE_SUB,
           HSIZE_SUB, HBURST_SUB, HPROT_SUB, HWDATA_SUB, HREADYOUT,
    output ACTIVE_SUB, HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT,
           HREADY, HWDATA
  );

  modport slave (
    output HSEL_SUB, TRANS_HOLD_SUB, HADDR_SUB, HTRANS_SUB, HWRITE_SUB,
           HSIZE_SUB, HBURST_SUB, HPROT_SUB, HWDATA_SUB, HREADYOUT,
    input  ACTIVE_SUB, HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT,
           HREADY, HWDATA
  );

endinterface

// File: rtl/ahblite_rr_arbiter.sv
// Round-robin address-phase arbiter with fixed-burst and INCR locking.
module ahblite_rr_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic [NUM_PORTS-1:0]         req,
  input  logic                         hready,
  input  logic [1:0]                   htrans,
  input  logic [2:0]                   hburst,
  output logic                         addr_valid,
  output logic [$clog2(NUM_PORTS)-1:0] addr_port
);

  localparam int PW = $clog2(NUM_PORTS);

  logic [PW-1:0] last_port;
  logic [3:0]    beat_cnt, beat_nxt, rem;
  logic          incr_lock, incr_nxt, locked;
  logic          found;
  logic [PW-1:0] sel, idx;

  // Lock state as it will be after the currently presented transfer is accepted.
  always_comb begin
    beat_nxt = beat_cnt;
    incr_nxt = incr_lock;
    rem      = burst_remaining(hburst_e'(hburst));
    case (htrans_e'(htrans))
      NONSEQ: begin
        if (rem != '0) beat_nxt = rem;
        incr_nxt = (hburst_e'(hburst) == INCR);
      end
      SEQ: begin
        if (beat_cnt != '0) beat_nxt = beat_cnt - 4'd1;
        if (hburst_e'(hburst) == INCR) incr_nxt = 1'b1;
      end
      BUSY: begin
        if (hburst_e'(hburst) == INCR) incr_nxt = 1'b1;
      end
      default: incr_nxt = 1'b0;
    endcase
    locked = (beat_nxt != '0) || incr_nxt;
  end

  // Scan starts just after the last winner; the last winner itself is checked last.
  always_comb begin
    found = 1'b0;
    sel   = last_port;
    idx   = '0;
    for (int unsigned off = 1; off <= NUM_PORTS; off++) begin
      idx = PW'((32'(last_port) + off) % NUM_PORTS);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      beat_cnt   <= '0;
      incr_lock  <= 1'b0;
      addr_valid <= 1'b0;
      addr_port  <= '0;
      last_port  <= PW'(NUM_PORTS - 1);
    end else if (hready) begin
      beat_cnt  <= beat_nxt;
      incr_lock <= incr_nxt;
      if (!locked) begin
        addr_valid <= found;
        if (found) begin
          addr_port <= sel;
          last_port <= sel;
        end
      end
    end
  end

endmodule

// File: rtl/ahblite_busmatrix_outputstage_rr.sv
// Bus-matrix output stage: merges NUM_PORTS input stages onto one AHB-Lite slave.
module ahblite_busmatrix_outputstage_rr
  import ahb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input logic                               HCLK,
  input logic                               HRESETn,
  ahblite_busmatrix_outputstage_rr_if.master bus
);

  localparam int PW = $clog2(NUM_PORTS);

  logic                 addr_valid, data_valid;
  logic [PW-1:0]        addr_port, data_port;
  logic [NUM_PORTS-1:0] req, active;
  logic                 hsel, hwrite, hready;
  logic [ADDR_W-1:0]    haddr;
  logic [1:0]           htrans;
  logic [2:0]           hsize, hburst;
  logic [3:0]           hprot;
  logic [DATA_W-1:0]    hwdata;

  assign req = bus.HSEL_SUB & bus.TRANS_HOLD_SUB;

  ahblite_rr_arbiter #(
    .NUM_PORTS(NUM_PORTS)
  ) u_arb (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .req       (req),
    .hready    (hready),
    .htrans    (htrans),
    .hburst    (hburst),
    .addr_valid(addr_valid),
    .addr_port (addr_port)
  );

  always_comb begin
    active = '0;
    hsel   = 1'b0;
    haddr  = '0;
    htrans = IDLE;
    hwrite = 1'b0;
    hsize  = '0;
    hburst = '0;
    hprot  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (addr_valid && addr_port == PW'(i)) begin
        active[i] = 1'b1;
        hsel      = bus.HSEL_SUB[i];
        haddr     = bus.HADDR_SUB[i*ADDR_W +: ADDR_W];
        htrans    = bus.HTRANS_SUB[i*2 +: 2];
        hwrite    = bus.HWRITE_SUB[i];
        hsize     = bus.HSIZE_SUB[i*3 +: 3];
        hburst    = bus.HBURST_SUB[i*3 +: 3];
        hprot     = bus.HPROT_SUB[i*4 +: 4];
      end
    end
  end

  always_comb begin
    hwdata = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (data_valid && data_port == PW'(i)) hwdata = bus.HWDATA_SUB[i*DATA_W +: DATA_W];
    end
  end

  assign hready = data_valid ? bus.HREADYOUT : 1'b1;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      data_valid <= 1'b0;
      data_port  <= '0;
    end else if (hready) begin
      data_valid <= hsel;
      data_port  <= addr_port;
    end
  end

  assign bus.ACTIVE_SUB = active;
  assign bus.HSEL       = hsel;
  assign bus.HADDR      = haddr;
  assign bus.HTRANS     = htrans;
  assign bus.HWRITE     = hwrite;
  assign bus.HSIZE      = hsize;
  assign bus.HBURST     = hburst;
  assign bus.HPROT      = hprot;
  assign bus.HREADY     = hready;
  assign bus.HWDATA     = hwdata;

endmodule

// File: tb/tb_ahblite_busmatrix_outputstage_rr.sv
// Bench for the round-robin output stage: directed scenarios plus random traffic vs a cycle model.
module tb_ahblite_busmatrix_outputstage_rr;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  localparam logic [1:0] T_IDLE = 2'd0, T_NONSEQ = 2'd2, T_SEQ = 2'd3;
  localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_INCR4 = 3'd3, B_INCR8 = 3'd5;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  ahblite_busmatrix_outputstage_rr_if #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  ahblite_busmatrix_outputstage_rr #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .bus    (bus)
  );

  // Per-port stimulus
  logic          sel[N], hold[N], wr[N];
  logic [AW-1:0] addr[N];
  logic [DW-1:0] wdata[N];
  logic [1:0]    trans[N];
  logic [2:0]    size[N], burst[N];
  logic [3:0]    prot[N];
  logic          hreadyout;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.HSEL_SUB[i]             = sel[i];
      bus.TRANS_HOLD_SUB[i]       = hold[i];
      bus.HWRITE_SUB[i]           = wr[i];
      bus.HADDR_SUB[i*AW +: AW]   = addr[i];
      bus.HWDATA_SUB[i*DW +: DW]  = wdata[i];
      bus.HTRANS_SUB[i*2 +: 2]    = trans[i];
      bus.HSIZE_SUB[i*3 +: 3]     = size[i];
      bus.HBURST_SUB[i*3 +: 3]    = burst[i];
      bus.HPROT_SUB[i*4 +: 4]     = prot[i];
    end
    bus.HREADYOUT = hreadyout;
  end

  // Reference model: who owns the address phase, who owns the data phase, and lock state
  bit         m_av, m_dv, m_incr;
  logic [1:0] m_ap, m_dp, m_last;
  int         m_beats;

  logic          exp_sel, exp_wr, exp_hready;
  logic [AW-1:0] exp_addr;
  logic [1:0]    exp_trans;
  logic [2:0]    exp_size, exp_burst;
  logic [3:0]    exp_prot, exp_act;
  logic [DW-1:0] exp_hwdata;

  always_comb begin
    exp_sel = 1'b0; exp_wr = 1'b0; exp_addr = '0; exp_trans = '0;
    exp_size = '0; exp_burst = '0; exp_prot = '0; exp_act = '0;
    if (m_av) begin
      exp_sel   = sel[m_ap];
      exp_wr    = wr[m_ap];
      exp_addr  = addr[m_ap];
      exp_trans = trans[m_ap];
      exp_size  = size[m_ap];
      exp_burst = burst[m_ap];
      exp_prot  = prot[m_ap];
      exp_act   = 4'd1 << m_ap;
    end
    exp_hready = m_dv ? hreadyout : 1'b1;
    exp_hwdata = m_dv ? wdata[m_dp] : '0;
  end

  task automatic model_edge();
    logic [1:0] t;
    logic [2:0] b;
    logic       s;
    logic [1:0] p;
    bit         found;
    if (!HRESETn) begin
      m_av = 0; m_dv = 0; m_incr = 0; m_beats = 0;
      m_ap = 0; m_dp = 0; m_last = 2'(N - 1);
      return;
    end
    if (!exp_hready) return;
    t = exp_trans; b = exp_burst; s = exp_sel;
    m_dv = s;
    m_dp = m_ap;
    case (t)
      2'd2: begin
        if (b == 3'd2 || b == 3'd3) m_beats = 3;
        else if (b == 3'd4 || b == 3'd5) m_beats = 7;
        else if (b == 3'd6 || b == 3'd7) m_beats = 15;
        m_incr = (b == 3'd1);
      end
      2'd3: begin
        if (m_beats > 0) m_beats = m_beats - 1;
        if (b == 3'd1) m_incr = 1;
      end
      2'd1: if (b == 3'd1) m_incr = 1;
      default: m_incr = 0;
    endcase
    if (!(m_beats > 0 || m_incr)) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        p = m_last + 2'(k);
        if (!found && sel[p] && hold[p]) begin
          found = 1; m_ap = p; m_last = p;
        end
      end
      m_av = found;
    end
  endtask

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("addr_ctl",
        64'({bus.HSEL, bus.HWRITE, bus.HTRANS, bus.HSIZE, bus.HBURST, bus.HPROT}),
        64'({exp_sel, exp_wr, exp_trans, exp_size, exp_burst, exp_prot}));
    chk("haddr",  64'(bus.HADDR),      64'(exp_addr));
    chk("active", 64'(bus.ACTIVE_SUB), 64'(exp_act));
    chk("hready", 64'(bus.HREADY),     64'(exp_hready));
    chk("hwdata", 64'(bus.HWDATA),     64'(exp_hwdata));
  endtask

  task automatic pre();  #1; check_all(); endtask
  task automatic post(); @(posedge HCLK); model_edge(); @(negedge HCLK); endtask
  task automatic tick(); pre(); post(); endtask
  task automatic do_reset(); HRESETn = 1'b0; post(); HRESETn = 1'b1; endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) begin
      sel[i] = 0; hold[i] = 0; wr[i] = 0; addr[i] = '0; wdata[i] = '0;
      trans[i] = T_IDLE; size[i] = '0; burst[i] = '0; prot[i] = '0;
    end
    hreadyout = 1'b1;
  endtask

  task automatic set_port(input int p, input logic [1:0] t, input logic [2:0] b, input logic [AW-1:0] a);
    sel[p] = 1; hold[p] = 1; wr[p] = 1; trans[p] = t; burst[p] = b; addr[p] = a;
    size[p] = 3'd2; prot[p] = 4'h3; wdata[p] = $urandom;
  endtask

  logic [3:0]    rr_exp[6];
  logic [DW-1:0] w0;

  initial begin
    rr_exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    idle_all();
    do_reset();

    // Reset outputs
    pre();
    chk("rst_active", 64'(bus.ACTIVE_SUB), 64'(0));
    chk("rst_hready", 64'(bus.HREADY), 64'(1));
    chk("rst_hsel",   64'(bus.HSEL), 64'(0));
    chk("rst_hwdata", 64'(bus.HWDATA), 64'(0));
    post();

    // Single write from port 0
    set_port(0, T_NONSEQ, B_SINGLE, 32'h4000_0000);
    w0 = wdata[0];
    pre(); chk("single_pre_active", 64'(bus.ACTIVE_SUB), 64'(0)); post();
    hold[0] = 0;
    pre();
    chk("single_active", 64'(bus.ACTIVE_SUB), 64'(4'b0001));
    chk("single_haddr",  64'(bus.HADDR), 64'(32'h4000_0000));
    chk("single_hsel",   64'(bus.HSEL), 64'(1));
    post();
    sel[0] = 0; trans[0] = T_IDLE;
    pre(); chk("single_hwdata", 64'(bus.HWDATA), 64'(w0)); post();
    tick();

    // Round robin over ports 0, 1, 3
    idle_all(); do_reset();
    set_port(0, T_NONSEQ, B_SINGLE, 32'h1000);
    set_port(1, T_NONSEQ, B_SINGLE, 32'h1100);
    set_port(3, T_NONSEQ, B_SINGLE, 32'h1300);
    tick();
    for (int i = 0; i < 6; i++) begin
      pre(); chk("rr_grant", 64'(bus.ACTIVE_SUB), 64'(rr_exp[i])); post();
    end

    // INCR4 on port 2 holds off port 0
    idle_all(); do_reset();
    set_port(2, T_NONSEQ, B_INCR4, 32'h2000);
    tick();
    set_port(0, T_NONSEQ, B_SINGLE, 32'h100);
    for (int bt = 0; bt < 4; bt++) begin
      if (bt > 0) begin trans[2] = T_SEQ; addr[2] = 32'h2000 + 32'(4 * bt); end
      if (bt == 3) hold[2] = 0;
      pre();
      chk("incr4_active", 64'(bus.ACTIVE_SUB), 64'(4'b0100));
      chk("incr4_haddr",  64'(bus.HADDR), 64'(32'h2000 + 32'(4 * bt)));
      post();
    end
    sel[2] = 0; trans[2] = T_IDLE;
    pre();
    chk("incr4_next_active", 64'(bus.ACTIVE_SUB), 64'(4'b0001));
    chk("incr4_next_haddr",  64'(bus.HADDR), 64'(32'h100));
    post();

    // Slave wait states freeze everything
    idle_all(); do_reset();
    set_port(0, T_NONSEQ, B_SINGLE, 32'h700);
    w0 = wdata[0];
    tick();
    pre(); chk("wait_first_active", 64'(bus.ACTIVE_SUB), 64'(4'b0001)); post();
    set_port(1, T_NONSEQ, B_SINGLE, 32'h800);
    hreadyout = 0;
    for (int i = 0; i < 3; i++) begin
      pre();
      chk("wait_hready", 64'(bus.HREADY), 64'(0));
      chk("wait_haddr",  64'(bus.HADDR), 64'(32'h700));
      chk("wait_active", 64'(bus.ACTIVE_SUB), 64'(4'b0001));
      chk("wait_hwdata", 64'(bus.HWDATA), 64'(w0));
      post();
    end
    hreadyout = 1;
    pre(); chk("wait_release", 64'(bus.HREADY), 64'(1)); post();
    pre(); chk("wait_next_active", 64'(bus.ACTIVE_SUB), 64'(4'b0010)); post();

    // Undefined-length INCR on port 1, port 2 waiting
    idle_all(); do_reset();
    set_port(1, T_NONSEQ, B_INCR, 32'h3000);
    set_port(2, T_NONSEQ, B_SINGLE, 32'h5000);
    tick();
    pre(); chk("incr_b1_active", 64'(bus.ACTIVE_SUB), 64'(4'b0010)); post();
    trans[1] = T_SEQ; addr[1] = 32'h3004;
    pre(); chk("incr_b2_active", 64'(bus.ACTIVE_SUB), 64'(4'b0010)); post();
    trans[1] = T_IDLE; hold[1] = 0;
    pre();
    chk("incr_idle_active", 64'(bus.ACTIVE_SUB), 64'(4'b0010));
    chk("incr_idle_htrans", 64'(bus.HTRANS), 64'(T_IDLE));
    post();
    sel[1] = 0;
    pre();
    chk("incr_p2_active", 64'(bus.ACTIVE_SUB), 64'(4'b0100));
    chk("incr_p2_haddr",  64'(bus.HADDR), 64'(32'h5000));
    post();

    // Reset in the middle of an INCR8
    idle_all(); do_reset();
    set_port(3, T_NONSEQ, B_INCR8, 32'h6000);
    tick();
    pre(); chk("incr8_active", 64'(bus.ACTIVE_SUB), 64'(4'b1000)); post();
    trans[3] = T_SEQ; addr[3] = 32'h6004;
    tick();
    addr[3] = 32'h6008;
    HRESETn = 0;
    tick();
    HRESETn = 1;
    trans[3] = T_NONSEQ;
    set_port(0, T_NONSEQ, B_SINGLE, 32'h10);
    pre();
    chk("midrst_active", 64'(bus.ACTIVE_SUB), 64'(0));
    chk("midrst_hsel",   64'(bus.HSEL), 64'(0));
    chk("midrst_haddr",  64'(bus.HADDR), 64'(0));
    chk("midrst_hready", 64'(bus.HREADY), 64'(1));
    chk("midrst_hwdata", 64'(bus.HWDATA), 64'(0));
    post();
    pre(); chk("midrst_p0_first", 64'(bus.ACTIVE_SUB), 64'(4'b0001)); post();

    // Random traffic against the model
    idle_all(); do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        sel[i]   = ($urandom_range(0, 3) != 0);
        hold[i]  = 1'($urandom);
        wr[i]    = 1'($urandom);
        addr[i]  = $urandom;
        wdata[i] = $urandom;
        trans[i] = 2'($urandom);
        size[i]  = 3'($urandom);
        burst[i] = 3'($urandom);
        prot[i]  = 4'($urandom);
      end
      hreadyout = ($urandom_range(0, 3) != 0);
      HRESETn   = ($urandom_range(0, 63) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
